// File: rtl/clk_reset_ctrl_if.sv
// clk_reset_ctrl_if: bundles the PLL/core-facing signals of the reset controller.
// master drives lock/request/kick and observes the resets; slave is the controller.
interface clk_reset_ctrl_if;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       wdt_kick;
    logic       periph_reset_n;
    logic       start_reset_n;
    logic       core_reset_n;
    logic       sys_ready;
    logic       lock_lost;
    logic [1:0] rst_cause;

    modport master (
        output pll_locked, sw_reset_req, wdt_kick,
        input  periph_reset_n, start_reset_n, core_reset_n,
               sys_ready, lock_lost, rst_cause
    );

    modport slave (
        input  pll_locked, sw_reset_req, wdt_kick,
        output periph_reset_n, start_reset_n, core_reset_n,
               sys_ready, lock_lost, rst_cause
    );
endinterface

// File: rtl/clk_reset_ctrl.sv
// clk_reset_ctrl: qualifies PLL lock, then releases peripheral, start-sequence
// and core resets in a staggered order; re-enters reset on lock loss or on a
// software request and records the cause.
// Optional watchdog: define RSTCTRL_WDT_EN to enable it.
module clk_reset_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int STAGE_GAP          = 16,
    parameter int SW_RST_CYCLES      = 32,
    parameter int WDT_TIMEOUT        = 65536
) (
    input  logic            clk,
    input  logic            reset_n,
    clk_reset_ctrl_if.slave bus
);

    localparam int MAX_AB  = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int MAX_SEQ = (MAX_AB > SW_RST_CYCLES) ? MAX_AB : SW_RST_CYCLES;
`ifdef RSTCTRL_WDT_EN
    localparam int MAX_CNT = (MAX_SEQ > WDT_TIMEOUT) ? MAX_SEQ : WDT_TIMEOUT;
`else
    localparam int MAX_CNT = MAX_SEQ;
`endif
    localparam int CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SWR_LAST  = CNT_W'(SW_RST_CYCLES - 1);
`ifdef RSTCTRL_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_TIMEOUT - 1);
`endif

    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
`ifdef RSTCTRL_WDT_EN
    localparam logic [1:0] CAUSE_WDT  = 2'b11;
`endif

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        REL_PERIPH,
        REL_START,
        REL_CORE,
        RUN,
        SW_RST
    } state_t;

    logic             r_sync1;
    logic             r_locked_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_periph_n;
    logic             r_start_n;
    logic             r_core_n;
    logic             r_ready;
    logic             r_lock_lost;
    logic [1:0]       r_cause;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_lock_lost_nxt;
    logic [1:0]       w_cause_nxt;
    logic             w_wdt_expire;
    logic             w_periph_nxt;
    logic             w_start_nxt;
    logic             w_core_nxt;
    logic             w_ready_nxt;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // The single counter doubles as the watchdog timer, since it is idle in RUN.
`ifdef RSTCTRL_WDT_EN
    assign w_wdt_expire = (r_state == RUN) && !bus.wdt_kick && (r_cnt == WDT_LAST);
`else
    assign w_wdt_expire = 1'b0;
`endif

    // Two-flop synchronizer for the PLL lock, which is asynchronous to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= bus.pll_locked;
            r_locked_s <= r_sync1;
        end
    end

    // Next-state logic; lock loss outranks the watchdog, which outranks software.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_lock_lost_nxt = r_lock_lost;
        w_cause_nxt     = r_cause;
        if (r_state != WAIT_LOCK && !r_locked_s) begin
            w_state_nxt = WAIT_LOCK;
            if (r_state != STABLE) begin
                w_lock_lost_nxt = 1'b1;
                w_cause_nxt     = CAUSE_LOCK;
            end
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (r_locked_s) begin
                        w_state_nxt = STABLE;
                    end
                end
                STABLE: begin
                    if (r_cnt == LOCK_LAST) w_state_nxt = REL_PERIPH;
                    else                    w_cnt_nxt   = w_cnt_inc;
                end
                REL_PERIPH: begin
                    if (r_cnt == GAP_LAST) w_state_nxt = REL_START;
                    else                   w_cnt_nxt   = w_cnt_inc;
                end
                REL_START: begin
                    if (r_cnt == GAP_LAST) w_state_nxt = REL_CORE;
                    else                   w_cnt_nxt   = w_cnt_inc;
                end
                REL_CORE: begin
                    if (r_cnt == GAP_LAST) w_state_nxt = RUN;
                    else                   w_cnt_nxt   = w_cnt_inc;
                end
                RUN: begin
                    if (w_wdt_expire) begin
                        w_state_nxt = SW_RST;
`ifdef RSTCTRL_WDT_EN
                        w_cause_nxt = CAUSE_WDT;
`endif
                    end else if (bus.sw_reset_req) begin
                        w_state_nxt = SW_RST;
                        w_cause_nxt = CAUSE_SW;
                    end else begin
`ifdef RSTCTRL_WDT_EN
                        if (!bus.wdt_kick) begin
                            w_cnt_nxt = w_cnt_inc;
                        end
`endif
                    end
                end
                SW_RST: begin
                    if (r_cnt == SWR_LAST) w_state_nxt = REL_PERIPH;
                    else                   w_cnt_nxt   = w_cnt_inc;
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                end
            endcase
        end
    end

    // Reset outputs are decoded from the next state so each release lands on the entering edge.
    always_comb begin
        w_periph_nxt = 1'b0;
        w_start_nxt  = 1'b0;
        w_core_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;
        case (w_state_nxt)
            REL_PERIPH: begin
                w_periph_nxt = 1'b1;
            end
            REL_START: begin
                w_periph_nxt = 1'b1;
                w_start_nxt  = 1'b1;
            end
            REL_CORE: begin
                w_periph_nxt = 1'b1;
                w_start_nxt  = 1'b1;
                w_core_nxt   = 1'b1;
            end
            RUN: begin
                w_periph_nxt = 1'b1;
                w_start_nxt  = 1'b1;
                w_core_nxt   = 1'b1;
                w_ready_nxt  = 1'b1;
            end
            default: begin
                w_periph_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_periph_n  <= 1'b0;
            r_start_n   <= 1'b0;
            r_core_n    <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
            r_cause     <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_periph_n  <= w_periph_nxt;
            r_start_n   <= w_start_nxt;
            r_core_n    <= w_core_nxt;
            r_ready     <= w_ready_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            r_cause     <= w_cause_nxt;
        end
    end

    assign bus.periph_reset_n = r_periph_n;
    assign bus.start_reset_n  = r_start_n;
    assign bus.core_reset_n   = r_core_n;
    assign bus.sys_ready      = r_ready;
    assign bus.lock_lost      = r_lock_lost;
    assign bus.rst_cause      = r_cause;

endmodule

// File: tb/tb_clk_reset_ctrl.sv
// tb_clk_reset_ctrl: directed scoreboard bench for clk_reset_ctrl.
// Expected output vectors are queued with the edge number they belong to and
// compared at the falling edge after that rising edge.
module tb_clk_reset_ctrl;

    localparam int L = 8;
    localparam int G = 4;
    localparam int S = 5;
    localparam int W = 20;

    typedef struct {
        string      tag;
        int         cycle;
        logic [6:0] exp;
    } expect_t;

    logic    clk = 1'b0;
    logic    reset_n;
    int      cyc;
    expect_t sb[$];
    int      nChecks = 0;
    int      nFails  = 0;

    clk_reset_ctrl_if bus ();

    clk_reset_ctrl #(
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP          (G),
        .SW_RST_CYCLES      (S),
        .WDT_TIMEOUT        (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running reference clock.
    always #5 clk = ~clk;

    // Rising-edge count since reset release; edge 1 is the first edge after release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Packs {periph, start, core, ready, lock_lost, cause}.
    function automatic logic [6:0] outs(input logic p, input logic s, input logic c,
                                        input logic r, input logic ll, input logic [1:0] cause);
        return {p, s, c, r, ll, cause};
    endfunction

    task automatic pushExpect(input string tag, input int cycle, input logic [6:0] exp);
        expect_t e;
        e.tag   = tag;
        e.cycle = cycle;
        e.exp   = exp;
        sb.push_back(e);
    endtask

    // Pops and compares every queued expectation that is due at the current edge.
    task automatic checkOutput();
        logic [6:0] obs;
        expect_t    e;
        obs = {bus.periph_reset_n, bus.start_reset_n, bus.core_reset_n,
               bus.sys_ready, bus.lock_lost, bus.rst_cause};
        while (sb.size() > 0 && sb[0].cycle <= cyc) begin
            e = sb.pop_front();
            nChecks++;
            if (e.cycle != cyc) begin
                assert (e.cycle == cyc) else begin
                    nFails++;
                    $error("[TB] FAIL %s: due at edge %0d, now at edge %0d", e.tag, e.cycle, cyc);
                end
            end else begin
                assert (obs === e.exp) else begin
                    nFails++;
                    $error("[TB] FAIL %s @edge %0d: observed %b expected %b", e.tag, cyc, obs, e.exp);
                end
            end
        end
    endtask

    // Advances to the falling edge after rising edge untilCycle, checking on the way.
    task automatic applyStimulus(input int untilCycle);
        int guard;
        guard = 0;
        while (cyc < untilCycle && guard < 2000) begin
            @(negedge clk);
            checkOutput();
            guard++;
        end
        if (cyc < untilCycle) begin
            nChecks++;
            nFails++;
            $error("[TB] FAIL advance: stuck at edge %0d, wanted %0d", cyc, untilCycle);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.pll_locked   = 1'b1;
        bus.sw_reset_req = 1'b0;
        bus.wdt_kick     = 1'b0;
        repeat (2) @(negedge clk);
        pushExpect("reset_values", 0, outs(0, 0, 0, 0, 0, 2'b00));
        checkOutput();
        reset_n = 1'b1;

        // Power-up with lock already high, then an ignored software request mid-release.
        pushExpect("pu_before_periph", 10, outs(0, 0, 0, 0, 0, 2'b00));
        pushExpect("pu_periph",        11, outs(1, 0, 0, 0, 0, 2'b00));
        pushExpect("pu_before_start",  14, outs(1, 0, 0, 0, 0, 2'b00));
        pushExpect("pu_start",         15, outs(1, 1, 0, 0, 0, 2'b00));
        pushExpect("pu_before_core",   18, outs(1, 1, 0, 0, 0, 2'b00));
        pushExpect("pu_core",          19, outs(1, 1, 1, 0, 0, 2'b00));
        pushExpect("pu_before_ready",  22, outs(1, 1, 1, 0, 0, 2'b00));
        pushExpect("pu_ready",         23, outs(1, 1, 1, 1, 0, 2'b00));
        pushExpect("run_steady",       25, outs(1, 1, 1, 1, 0, 2'b00));
        pushExpect("swr_assert",       26, outs(0, 0, 0, 0, 0, 2'b10));
        pushExpect("swr_hold",         30, outs(0, 0, 0, 0, 0, 2'b10));
        pushExpect("swr_periph",       31, outs(1, 0, 0, 0, 0, 2'b10));
        pushExpect("swr_start",        35, outs(1, 1, 0, 0, 0, 2'b10));
        pushExpect("swr_ignored",      37, outs(1, 1, 0, 0, 0, 2'b10));
        pushExpect("swr_core",         39, outs(1, 1, 1, 0, 0, 2'b10));
        pushExpect("swr_before_ready", 42, outs(1, 1, 1, 0, 0, 2'b10));
        pushExpect("swr_ready",        43, outs(1, 1, 1, 1, 0, 2'b10));
        applyStimulus(25);
        bus.sw_reset_req = 1'b1;
        applyStimulus(26);
        bus.sw_reset_req = 1'b0;
        applyStimulus(36);
        bus.sw_reset_req = 1'b1;
        applyStimulus(37);
        bus.sw_reset_req = 1'b0;
        applyStimulus(45);

        // Lock drop in RUN, then full requalification.
        bus.pll_locked = 1'b0;
        pushExpect("loss_still_run", 47, outs(1, 1, 1, 1, 0, 2'b10));
        pushExpect("loss_asserted",  48, outs(0, 0, 0, 0, 1, 2'b01));
        applyStimulus(50);
        bus.pll_locked = 1'b1;
        pushExpect("requal_hold",   60, outs(0, 0, 0, 0, 1, 2'b01));
        pushExpect("requal_periph", 61, outs(1, 0, 0, 0, 1, 2'b01));
        pushExpect("requal_start",  65, outs(1, 1, 0, 0, 1, 2'b01));
        pushExpect("requal_core",   69, outs(1, 1, 1, 0, 1, 2'b01));
        pushExpect("requal_ready",  73, outs(1, 1, 1, 1, 1, 2'b01));
        applyStimulus(74);

        // Lock loss and software request seen on the same edge: lock loss wins.
        bus.pll_locked = 1'b0;
        pushExpect("both_before", 76, outs(1, 1, 1, 1, 1, 2'b01));
        pushExpect("both_edge",   77, outs(0, 0, 0, 0, 1, 2'b01));
        pushExpect("both_after",  80, outs(0, 0, 0, 0, 1, 2'b01));
        applyStimulus(76);
        bus.sw_reset_req = 1'b1;
        applyStimulus(77);
        bus.sw_reset_req = 1'b0;
        applyStimulus(80);
        bus.pll_locked = 1'b1;
        pushExpect("relock_hold",   90, outs(0, 0, 0, 0, 1, 2'b01));
        pushExpect("relock_periph", 91, outs(1, 0, 0, 0, 1, 2'b01));
        applyStimulus(92);

        // Asynchronous reset in the middle of a release sequence.
        reset_n = 1'b0;
        #1;
        pushExpect("async_reset", 0, outs(0, 0, 0, 0, 0, 2'b00));
        checkOutput();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Three-cycle lock glitch during qualification restarts the count.
        pushExpect("glitch_stable",     7, outs(0, 0, 0, 0, 0, 2'b00));
        pushExpect("glitch_no_early",  11, outs(0, 0, 0, 0, 0, 2'b00));
        pushExpect("glitch_hold",      18, outs(0, 0, 0, 0, 0, 2'b00));
        pushExpect("glitch_periph",    19, outs(1, 0, 0, 0, 0, 2'b00));
        pushExpect("glitch_start",     23, outs(1, 1, 0, 0, 0, 2'b00));
        pushExpect("glitch_core",      27, outs(1, 1, 1, 0, 0, 2'b00));
        pushExpect("glitch_pre_ready", 30, outs(1, 1, 1, 0, 0, 2'b00));
        pushExpect("glitch_ready",     31, outs(1, 1, 1, 1, 0, 2'b00));
        applyStimulus(5);
        bus.pll_locked = 1'b0;
        applyStimulus(8);
        bus.pll_locked = 1'b1;
        applyStimulus(33);

`ifdef RSTCTRL_WDT_EN
        // Watchdog expiry with no kicks, then regular kicks keep RUN alive.
        pushExpect("wdt_before",      50, outs(1, 1, 1, 1, 0, 2'b00));
        pushExpect("wdt_expire",      51, outs(0, 0, 0, 0, 0, 2'b11));
        pushExpect("wdt_hold",        55, outs(0, 0, 0, 0, 0, 2'b11));
        pushExpect("wdt_periph",      56, outs(1, 0, 0, 0, 0, 2'b11));
        pushExpect("wdt_start",       60, outs(1, 1, 0, 0, 0, 2'b11));
        pushExpect("wdt_core",        64, outs(1, 1, 1, 0, 0, 2'b11));
        pushExpect("wdt_ready",       68, outs(1, 1, 1, 1, 0, 2'b11));
        pushExpect("wdt_kicked_88",   88, outs(1, 1, 1, 1, 0, 2'b11));
        pushExpect("wdt_kicked_96",   96, outs(1, 1, 1, 1, 0, 2'b11));
        pushExpect("wdt_kicked_110", 110, outs(1, 1, 1, 1, 0, 2'b11));
        applyStimulus(68);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(75 + 10 * k);
            bus.wdt_kick = 1'b1;
            applyStimulus(76 + 10 * k);
            bus.wdt_kick = 1'b0;
        end
        applyStimulus(112);
`endif

        if (sb.size() > 0) begin
            nChecks++;
            nFails++;
            $error("[TB] FAIL drain: %0d expectations left unchecked", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/clk_reset_ctrl.md
# clk_reset_ctrl

Reset and bring-up controller for the CPU subsystem. It watches the PLL lock indication, requires lock to be stable for a programmable time, then releases the peripheral, start-sequence and core resets in a fixed staggered order. It re-enters reset on PLL lock loss or on a software reset request, and records the cause. It sits between the board clock/reset and the PLL, core, start-sequence and peripheral blocks.

## Interface
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release (≥2).
- STAGE_GAP, 16: cycles between successive reset deassertions (≥1).
- SW_RST_CYCLES, 32: cycles all resets are held for a software reset (≥1).
- WDT_TIMEOUT, 65536: watchdog timeout in cycles (used only with RSTCTRL_WDT_EN).

Ports:
- clk  in  1  board reference clock, free-running, not the PLL output.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock, asynchronous to clk; 2-flop synchronized internally (locked_s).
- sw_reset_req  in  1  single-cycle software reset request from core.
- wdt_kick  in  1  watchdog kick pulse; ignored without RSTCTRL_WDT_EN.
- periph_reset_n  out  1  peripheral reset, active-low.
- start_reset_n  out  1  start-sequence reset, active-low.
- core_reset_n  out  1  core reset, active-low.
- sys_ready  out  1  high only in RUN.
- lock_lost  out  1  sticky: lock lost at least once since reset_n.
- rst_cause  out  2  00 power-on, 01 lock loss, 10 software, 11 watchdog.

## Operation
- All outputs registered; reset values: periph/start/core_reset_n=0, sys_ready=0, lock_lost=0, rst_cause=00; FSM=WAIT_LOCK, counters=0, sync flops=0.
- States: WAIT_LOCK, STABLE, REL_PERIPH, REL_START, REL_CORE, RUN, SW_RST.
- WAIT_LOCK: all resets asserted; locked_s=1 -> STABLE, counter=0.
- STABLE: counter increments while locked_s=1; counter==LOCK_STABLE_CYCLES-1 -> REL_PERIPH.
- REL_PERIPH (periph released on entry) -> REL_START after STAGE_GAP cycles -> REL_CORE after STAGE_GAP -> RUN after STAGE_GAP. Outputs decoded from next state; a release is visible on the entering edge.
- RUN: all resets released, sys_ready=1.
- Lock loss: locked_s=0 in any state except WAIT_LOCK -> next edge all resets asserted, sys_ready=0, state WAIT_LOCK. lock_lost set and rst_cause=01 only if loss occurs in REL_*/RUN/SW_RST; loss in STABLE just restarts qualification.
- sw_reset_req honoured only in RUN: -> SW_RST, all resets asserted, rst_cause=10; after SW_RST_CYCLES -> REL_PERIPH, skipping lock qualification. Ignored in all other states.
- Priority per cycle: lock loss > watchdog > sw_reset_req.
- lock_lost cleared only by reset_n. rst_cause holds its last value until the next event.
- Counters sized $clog2 of the largest parameter; no wrap reachable.

## Timing
- reset_n assertion forces the reset values asynchronously, mid-sequence included; deassertion is taken at the next clk edge.
- pll_locked high before reset_n release: locked_s=1 after edge 2, STABLE entered at edge 3, periph_reset_n rises at edge N=3+LOCK_STABLE_CYCLES, start at N+STAGE_GAP, core at N+2·STAGE_GAP, sys_ready at N+3·STAGE_GAP.
- Lock-loss response: 3 edges from pll_locked falling to resets asserted (2 sync + 1 register).
- sw_reset_req at edge E in RUN: resets asserted at E+1, periph released at E+1+SW_RST_CYCLES.

## Configuration
- RSTCTRL_WDT_EN defined: watchdog counter runs only in RUN and clears on wdt_kick or on entry to RUN. When it reaches WDT_TIMEOUT-1 without a kick, the FSM enters SW_RST with rst_cause=11; SW_RST timing is otherwise identical.
- Undefined: no watchdog logic, wdt_kick unused, rst_cause never 11.

## Test plan
- Power-up, LOCK_STABLE_CYCLES=8, STAGE_GAP=4, lock high -> periph_reset_n rises at edge 11, start at 15, core at 19, sys_ready at 23, rst_cause=00.
- Lock glitch low 3 cycles during STABLE -> counter restarts, lock_lost stays 0, periph release delayed by 8 cycles after relock.
- Lock drop in RUN -> all resets low 3 edges later, sys_ready=0, lock_lost=1, rst_cause=01; full requalification on relock.
- sw_reset_req in RUN with SW_RST_CYCLES=5 -> resets low for 5 cycles, then staggered release with no requalification, rst_cause=10. Same request during REL_START -> ignored.
- Lock loss and sw_reset_req on the same edge in RUN -> WAIT_LOCK, rst_cause=01.
- RSTCTRL_WDT_EN, WDT_TIMEOUT=20, no kicks -> SW_RST at 20 cycles into RUN, rst_cause=11. Kicks every 10 cycles -> no reset.
